// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, drives the instruction memory
// and buffers {pc, inst} pairs in a small FIFO that is discarded on redirect.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic [31:0]              im_addr,
   input  logic [31:0]              im_dout,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_inst,
   output logic [31:0]              fetch_pc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [31:0]      pc_mem   [DEPTH];
   logic [31:0]      inst_mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic             full;
   logic             push;
   logic             pop;

   assign im_addr = fetch_pc;

   always_comb begin
      full      = (count == DEPTH_C);
      out_valid = (count != '0);
      pop       = out_valid & out_ready & ~redirect;
      // A full queue may still accept a fetch when the head leaves this cycle.
      push      = ~redirect & (~full | pop);
      out_pc    = out_valid ? pc_mem[head]   : 32'h0;
      out_inst  = out_valid ? inst_mem[head] : NOP_INST;
   end

   // Fetch stage -> queue: control state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc <= RESET_PC;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else if (redirect) begin
         fetch_pc <= {redirect_pc[31:2], 2'b00};
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            tail     <= tail + PTR_W'(1);
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (pop) begin
            head <= head + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   // Queue storage carries data only, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[tail]   <= fetch_pc;
         inst_mem[tail] <= im_dout;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, checked against
// a queue-based reference model of the fetch front end.
module tb_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] im_addr;
   logic [31:0] im_dout;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic [31:0] fetch_pc;
   logic [$clog2(DEPTH):0] count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_q[$];
   logic [31:0] m_pc;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
      .clk(clk), .rst(rst), .im_addr(im_addr), .im_dout(im_dout),
      .redirect(redirect), .redirect_pc(redirect_pc), .out_ready(out_ready),
      .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
      .fetch_pc(fetch_pc), .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   always_comb im_dout = mem_word(im_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_model();
      int sz = m_q.size();
      chk("out_valid", 32'(out_valid), 32'(sz != 0));
      chk("out_pc",    out_pc,   (sz != 0) ? m_q[0] : 32'h0);
      chk("out_inst",  out_inst, (sz != 0) ? mem_word(m_q[0]) : NOP_INST);
      chk("count",     32'(count), 32'(sz));
      chk("fetch_pc",  fetch_pc, m_pc);
      chk("im_addr",   im_addr,  m_pc);
   endtask

   // Called just after a falling edge; applies inputs, checks, then advances one edge.
   task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc);
      bit do_pop;
      bit do_push;
      out_ready   = rdy;
      redirect    = rd;
      redirect_pc = rpc;
      #1;
      chk_model();
      @(posedge clk);
      if (rd) begin
         m_q.delete();
         m_pc = rpc & 32'hFFFF_FFFC;
      end else begin
         do_pop  = (m_q.size() != 0) && rdy;
         do_push = (m_q.size() < DEPTH) || do_pop;
         if (do_pop) void'(m_q.pop_front());
         if (do_push) begin
            m_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      m_q.delete();
      m_pc = RESET_PC;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk_model();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      out_ready = 1'b1;
      redirect = 1'b0;
      redirect_pc = 32'h0;

      // Reset and stream
      do_reset();
      chk("rst_im_addr", im_addr, 32'h0000_3000);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);
      chk("stream_count", 32'(count), 32'd1);

      // Backpressure from reset release, then drain in order
      do_reset();
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);
      chk("bp_count", 32'(count), 32'd4);
      chk("bp_fetch_pc", fetch_pc, 32'h0000_3010);
      step(1'b1, 1'b0, 32'h0);
      chk("full_pushpop_count", 32'(count), 32'd4);
      chk("full_pushpop_head", out_pc, 32'h0000_3004);

      // Redirect while full with out_ready high
      step(1'b1, 1'b1, 32'h0000_3041);
      chk("redir_valid", 32'(out_valid), 32'd0);
      chk("redir_inst", out_inst, 32'h0000_0013);
      chk("redir_fetch_pc", fetch_pc, 32'h0000_3040);
      step(1'b1, 1'b0, 32'h0);
      chk("redir_target", out_pc, 32'h0000_3040);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);

      // Redirect held for several cycles
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'h0000_5000 + 32'(i * 16));

      // Address wrap and pointer wrap
      step(1'b1, 1'b1, 32'hFFFF_FFF8);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'hFFFF_FFF0);
      for (int i = 0; i < 12; i++) step(i[0], 1'b0, 32'h0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                           : $urandom;
         step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rpc);
      end

      // Asynchronous reset between edges with three entries queued
      step(1'b0, 1'b1, 32'h0000_7000);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
      chk("pre_async_count", 32'(count), 32'd3);
      #2;
      rst = 1'b0;
      #1;
      chk("async_valid", 32'(out_valid), 32'd0);
      chk("async_count", 32'(count), 32'd0);
      chk("async_fetch_pc", fetch_pc, 32'h0000_3000);
      chk("async_im_addr", im_addr, 32'h0000_3000);
      m_q.delete();
      m_pc = RESET_PC;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
